// File: rtl/polar_conv_ctrl.sv
// Time-shares one rec2pol CORDIC core between complex operands A and B,
// capturing modulus/angle per operand after a fixed core latency.
module polar_conv_ctrl #(
    parameter int CORE_LAT = 34
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  sel,
    input  logic [31:0] re_a,
    input  logic [31:0] im_a,
    input  logic [31:0] re_b,
    input  logic [31:0] im_b,
    output logic        core_enable,
    output logic        core_start,
    output logic [31:0] core_x,
    output logic [31:0] core_y,
    input  logic [31:0] core_mod,
    input  logic [31:0] core_angle,
    output logic        busy,
    output logic        done,
    output logic [31:0] mod_a,
    output logic [31:0] ang_a,
    output logic [31:0] mod_b,
    output logic [31:0] ang_b
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        WAIT_A,
        LOAD_B,
        WAIT_B,
        DONE
    } state_t;

    localparam logic [7:0] LAST = 8'(CORE_LAT - 1);

    state_t      state;
    logic [7:0]  cnt;
    logic        sel_b_q;
    logic [31:0] re_a_q;
    logic [31:0] im_a_q;
    logic [31:0] re_b_q;
    logic [31:0] im_b_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            sel_b_q     <= 1'b0;
            re_a_q      <= '0;
            im_a_q      <= '0;
            re_b_q      <= '0;
            im_b_q      <= '0;
            core_enable <= 1'b0;
            core_start  <= 1'b0;
            core_x      <= '0;
            core_y      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            mod_a       <= '0;
            ang_a       <= '0;
            mod_b       <= '0;
            ang_b       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        re_a_q  <= re_a;
                        im_a_q  <= im_a;
                        re_b_q  <= re_b;
                        im_b_q  <= im_b;
                        sel_b_q <= sel[1];
                        busy    <= 1'b1;
                        if (sel[0]) begin
                            state       <= LOAD_A;
                            core_start  <= 1'b1;
                            core_enable <= 1'b1;
                            core_x      <= re_a;
                            core_y      <= im_a;
                        end else if (sel[1]) begin
                            state       <= LOAD_B;
                            core_start  <= 1'b1;
                            core_enable <= 1'b1;
                            core_x      <= re_b;
                            core_y      <= im_b;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                LOAD_A: begin
                    core_start <= 1'b0;
                    core_x     <= re_a_q;
                    core_y     <= im_a_q;
                    cnt        <= '0;
                    state      <= WAIT_A;
                end
                WAIT_A: begin
                    cnt <= cnt + 8'd1;
                    if (cnt == LAST) begin
                        mod_a <= core_mod;
                        ang_a <= core_angle;
                        // A then B: go straight into the second core run
                        if (sel_b_q) begin
                            state      <= LOAD_B;
                            core_start <= 1'b1;
                            core_x     <= re_b_q;
                            core_y     <= im_b_q;
                        end else begin
                            state       <= DONE;
                            core_enable <= 1'b0;
                            done        <= 1'b1;
                        end
                    end
                end
                LOAD_B: begin
                    core_start <= 1'b0;
                    core_x     <= re_b_q;
                    core_y     <= im_b_q;
                    cnt        <= '0;
                    state      <= WAIT_B;
                end
                WAIT_B: begin
                    cnt <= cnt + 8'd1;
                    if (cnt == LAST) begin
                        mod_b       <= core_mod;
                        ang_b       <= core_angle;
                        state       <= DONE;
                        core_enable <= 1'b0;
                        done        <= 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_polar_conv_ctrl.sv
// Bench for polar_conv_ctrl: fixed-latency core model, schedule-based
// reference model checked every cycle, plus directed literal checks.
module tb_polar_conv_ctrl;

    localparam int L  = 34;
    localparam int L2 = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        start2 = 1'b0;
    logic [1:0]  sel = 2'b00;
    logic [31:0] re_a = '0, im_a = '0, re_b = '0, im_b = '0;

    logic        core_enable, core_start, busy, done;
    logic [31:0] core_x, core_y, mod_a, ang_a, mod_b, ang_b;
    logic [31:0] core_mod = '0, core_angle = '0;

    logic        core_enable2, core_start2, busy2, done2;
    logic [31:0] core_x2, core_y2, mod_a2, ang_a2, mod_b2, ang_b2;
    logic [31:0] core_mod2 = '0, core_angle2 = '0;

    int n_chk = 0, n_fail = 0, n_cs = 0, n_done = 0;
    int cyc = 0;

    always #5 clock = ~clock;

    polar_conv_ctrl #(.CORE_LAT(L)) dut (
        .clock(clock), .reset(reset), .start(start), .sel(sel),
        .re_a(re_a), .im_a(im_a), .re_b(re_b), .im_b(im_b),
        .core_enable(core_enable), .core_start(core_start),
        .core_x(core_x), .core_y(core_y),
        .core_mod(core_mod), .core_angle(core_angle),
        .busy(busy), .done(done),
        .mod_a(mod_a), .ang_a(ang_a), .mod_b(mod_b), .ang_b(ang_b)
    );

    polar_conv_ctrl #(.CORE_LAT(L2)) dut2 (
        .clock(clock), .reset(reset), .start(start2), .sel(sel),
        .re_a(re_a), .im_a(im_a), .re_b(re_b), .im_b(im_b),
        .core_enable(core_enable2), .core_start(core_start2),
        .core_x(core_x2), .core_y(core_y2),
        .core_mod(core_mod2), .core_angle(core_angle2),
        .busy(busy2), .done(done2),
        .mod_a(mod_a2), .ang_a(ang_a2), .mod_b(mod_b2), .ang_b(ang_b2)
    );

    // Core models: result = x+y / x^y, valid CORE_LAT cycles after start
    int cnt1 = 0, cnt2 = 0;
    logic [31:0] px1 = '0, py1 = '0, px2 = '0, py2 = '0;

    always @(posedge clock) begin
        if (core_start) begin
            cnt1 <= L - 1; px1 <= core_x; py1 <= core_y;
            core_mod <= 32'hBAD0_BAD0; core_angle <= 32'hBAD0_BAD0;
        end else if (cnt1 != 0) begin
            cnt1 <= cnt1 - 1;
            if (cnt1 == 1) begin
                core_mod <= px1 + py1; core_angle <= px1 ^ py1;
            end
        end
    end

    always @(posedge clock) begin
        if (core_start2) begin
            cnt2 <= L2 - 1; px2 <= core_x2; py2 <= core_y2;
            core_mod2 <= 32'hBAD0_BAD0; core_angle2 <= 32'hBAD0_BAD0;
        end else if (cnt2 != 0) begin
            cnt2 <= cnt2 - 1;
            if (cnt2 == 1) begin
                core_mod2 <= px2 + py2; core_angle2 <= px2 ^ py2;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Reference model: request schedule computed at acceptance
    bit          mvalid = 0, m_act = 0;
    int          m_la = -1, m_lb = -1, m_dc = -1;
    logic [31:0] l_ra = '0, l_ia = '0, l_rb = '0, l_ib = '0;
    logic [31:0] e_x = '0, e_y = '0;
    logic [31:0] e_ma = '0, e_aa = '0, e_mb = '0, e_ab = '0;

    always @(posedge clock) begin
        int  c;
        bit  idle;
        c = cyc;
        if (reset) begin
            mvalid = 1; m_act = 0;
            m_la = -1; m_lb = -1; m_dc = -1;
            l_ra = '0; l_ia = '0; l_rb = '0; l_ib = '0;
            e_x = '0; e_y = '0;
            e_ma = '0; e_aa = '0; e_mb = '0; e_ab = '0;
        end else begin
            idle = !m_act;
            if (m_act) begin
                if (m_la >= 0 && c == m_la + L) begin
                    e_ma = l_ra + l_ia; e_aa = l_ra ^ l_ia;
                end
                if (m_lb >= 0 && c == m_lb + L) begin
                    e_mb = l_rb + l_ib; e_ab = l_rb ^ l_ib;
                end
                if (c == m_dc) m_act = 0;
            end
            if (idle && start) begin
                l_ra = re_a; l_ia = im_a; l_rb = re_b; l_ib = im_b;
                m_act = 1;
                m_la = sel[0] ? c + 1 : -1;
                m_lb = !sel[1] ? -1 : (sel[0] ? c + 2 + L : c + 1);
                m_dc = (sel == 2'b00) ? c + 1 :
                       (sel == 2'b11) ? c + 3 + 2 * L : c + 2 + L;
            end
            if (m_act && c + 1 == m_la) begin e_x = l_ra; e_y = l_ia; end
            if (m_act && c + 1 == m_lb) begin e_x = l_rb; e_y = l_ib; end
        end
        cyc = c + 1;
    end

    always @(negedge clock) begin
        logic e_en;
        if (mvalid) begin
            e_en = m_act &&
                   ((m_la >= 0 && cyc >= m_la && cyc <= m_la + L) ||
                    (m_lb >= 0 && cyc >= m_lb && cyc <= m_lb + L));
            chk("busy", 32'(busy), 32'(m_act));
            chk("done", 32'(done), 32'(m_act && cyc == m_dc));
            chk("core_start", 32'(core_start),
                32'(m_act && (cyc == m_la || cyc == m_lb)));
            chk("core_enable", 32'(core_enable), 32'(e_en));
            chk("core_x", core_x, e_x);
            chk("core_y", core_y, e_y);
            chk("mod_a", mod_a, e_ma);
            chk("ang_a", ang_a, e_aa);
            chk("mod_b", mod_b, e_mb);
            chk("ang_b", ang_b, e_ab);
            if (core_start) n_cs++;
            if (done) n_done++;
        end
    end

    task automatic goto(input int target);
        int n = 0;
        while (cyc < target && n < 2000) begin
            @(negedge clock);
            n++;
        end
        chk("goto", 32'(cyc), 32'(target));
    endtask

    task automatic run_start(input logic [1:0] s, output int t);
        sel = s; start = 1'b1; t = cyc;
        @(negedge clock);
        start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t, ns0, nd0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cstart", 32'(core_start), 32'd0);
        chk("rst_cen", 32'(core_enable), 32'd0);
        chk("rst_core_x", core_x, 32'd0);
        chk("rst_mod_a", mod_a, 32'd0);
        chk("rst_ang_b", ang_b, 32'd0);
        @(negedge clock);

        // A only
        re_a = 32'h0001_0000; im_a = 32'h0002_0000;
        run_start(2'b01, t);
        chk("a_cstart", 32'(core_start), 32'd1);
        chk("a_core_x", core_x, 32'h0001_0000);
        chk("a_core_y", core_y, 32'h0002_0000);
        goto(t + 35);
        chk("a_done_early", 32'(done), 32'd0);
        goto(t + 36);
        chk("a_done", 32'(done), 32'd1);
        chk("a_mod_a", mod_a, 32'h0003_0000);
        chk("a_ang_a", ang_a, 32'h0003_0000);
        chk("a_mod_b", mod_b, 32'd0);
        chk("a_model_ma", e_ma, 32'h0003_0000);
        @(negedge clock);
        chk("a_idle", 32'(busy), 32'd0);

        // Both, with operand changes and ignored starts while busy
        re_a = 32'h0005_0000; im_a = 32'h0001_0000;
        re_b = 32'h0002_0000; im_b = 32'h0002_0000;
        #1; ns0 = n_cs; nd0 = n_done;
        @(negedge clock);
        run_start(2'b11, t);
        goto(t + 5);
        re_a = 32'h1234_0000; im_a = 32'h0F0F_0000;
        re_b = 32'h7777_0000; im_b = 32'h0101_0000;
        sel = 2'b01; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        goto(t + 36);
        chk("ab_cstart_b", 32'(core_start), 32'd1);
        chk("ab_core_x_b", core_x, 32'h0002_0000);
        goto(t + 70);
        chk("ab_done_early", 32'(done), 32'd0);
        goto(t + 71);
        chk("ab_done", 32'(done), 32'd1);
        chk("ab_mod_a", mod_a, 32'h0006_0000);
        chk("ab_ang_a", ang_a, 32'h0004_0000);
        chk("ab_mod_b", mod_b, 32'h0004_0000);
        chk("ab_ang_b", ang_b, 32'd0);
        chk("ab_model_mb", e_mb, 32'h0004_0000);
        sel = 2'b00; start = 1'b1;
        @(negedge clock);
        chk("ab_idle_gap", 32'(busy), 32'd0);
        @(negedge clock);
        start = 1'b0;
        chk("s00_done", 32'(done), 32'd1);
        chk("s00_cstart", 32'(core_start), 32'd0);
        @(negedge clock);
        #1;
        chk("ab_cstart_cnt", 32'(n_cs - ns0), 32'd2);
        chk("ab_done_cnt", 32'(n_done - nd0), 32'd2);
        chk("s00_mod_a", mod_a, 32'h0006_0000);
        chk("s00_mod_b", mod_b, 32'h0004_0000);

        // Reset mid-run
        @(negedge clock);
        re_a = 32'h0007_0000; im_a = 32'h0001_0000;
        run_start(2'b01, t);
        goto(t + 20);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_cen", 32'(core_enable), 32'd0);
        chk("mr_core_x", core_x, 32'd0);
        chk("mr_mod_a", mod_a, 32'd0);
        chk("mr_mod_b", mod_b, 32'd0);
        #1; nd0 = n_done;
        goto(t + 45);
        #1;
        chk("mr_no_done", 32'(n_done - nd0), 32'd0);
        @(negedge clock);
        re_a = 32'h0003_0000; im_a = 32'h0004_0000;
        run_start(2'b01, t);
        goto(t + 36);
        chk("mr2_done", 32'(done), 32'd1);
        chk("mr2_mod_a", mod_a, 32'h0007_0000);
        chk("mr2_ang_a", ang_a, 32'h0007_0000);

        // CORE_LAT = 2 instance, A only
        @(negedge clock);
        @(negedge clock);
        re_a = 32'h0001_0000; im_a = 32'h0002_0000; sel = 2'b01;
        start2 = 1'b1; t = cyc;
        @(negedge clock);
        start2 = 1'b0;
        chk("l2_cstart", 32'(core_start2), 32'd1);
        chk("l2_core_y", core_y2, 32'h0002_0000);
        goto(t + 3);
        chk("l2_done_early", 32'(done2), 32'd0);
        goto(t + 4);
        chk("l2_done", 32'(done2), 32'd1);
        chk("l2_mod_a", mod_a2, 32'h0003_0000);
        chk("l2_ang_a", ang_a2, 32'h0003_0000);
        chk("l2_mod_b", mod_b2, 32'd0);
        @(negedge clock);
        chk("l2_idle", 32'(busy2), 32'd0);

        repeat (2) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
